// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment receive path.
//   SEG_GLYPH   - active-low segment patterns for hex nibbles 0..F
//                 (bit7=a .. bit1=g, bit0=dp, dp forced off here)
//   SEG_BLANK   - all segments and dp dark
//   SEG_DP_MASK - OR-mask that removes the dp bit before glyph matching
//   state_t     - receive FSM states
package seg_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] SEG_DP_MASK = 8'h01;

    localparam logic [7:0] SEG_GLYPH [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/seg_decode_digit.sv
// seg_decode_digit: combinational decode of one active-low segment byte.
// Ports:
//   seg  in  8  segment byte, bit7=a .. bit1=g, bit0=dp (active-low)
//   hex  out 4  glyph index; 0 when blank or unrecognised
//   en   out 1  digit shows a legal glyph
//   dp   out 1  decimal point lit
//   err  out 1  some segment lit but the pattern is not a known glyph
module seg_decode_digit
    import seg_pkg::*;
(
    input  logic [7:0] seg,
    output logic [3:0] hex,
    output logic       en,
    output logic       dp,
    output logic       err
);

    logic [7:0] q;
    logic       hit;

    always_comb begin
        q   = seg | SEG_DP_MASK;
        hex = '0;
        en  = 1'b0;
        err = 1'b0;
        hit = 1'b0;
        dp  = ~seg[0];
        if (q != SEG_BLANK) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (!hit && q == SEG_GLYPH[i]) begin
                    hit = 1'b1;
                    hex = 4'(i);
                end
            end
            en  = hit;
            err = ~hit;
        end
    end

endmodule

// File: rtl/seg_rx.sv
// seg_rx: receive end of the seven-segment interface.
// Samples NDIGIT active-low segment bytes, waits until the whole frame has
// been unchanged for STABLE_CYCLES samples, decodes every digit and presents
// each new stable frame once on a valid/ready output.
// Ports:
//   clk       in   1          rising-edge clock
//   rst       in   1          synchronous reset, active-high
//   seg_in    in   8*NDIGIT   segment bytes, digit i = seg_in[8*i+7:8*i]
//   out_ready in   1          consumer accepts the held frame
//   out_valid out  1          decoded frame held on out_* buses
//   out_hex   out  4*NDIGIT   decoded nibble per digit
//   out_en    out  NDIGIT     digit lit with a legal glyph
//   out_dp    out  NDIGIT     decimal point lit
//   out_err   out  NDIGIT     digit lit with an unknown pattern
//   overrun   out  1          sticky: new stable frame seen while stalled
module seg_rx
    import seg_pkg::*;
#(
    parameter int NDIGIT        = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NDIGIT-1:0]   seg_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*NDIGIT-1:0]   out_hex,
    output logic [NDIGIT-1:0]     out_en,
    output logic [NDIGIT-1:0]     out_dp,
    output logic [NDIGIT-1:0]     out_err,
    output logic                  overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [8*NDIGIT-1:0] seg_q;
    logic [8*NDIGIT-1:0] last;
    logic [CNT_W-1:0]    cnt;
    state_t              state, state_n;

    logic                stable;
    logic                fresh;
    logic                load;
    logic                release_v;
    logic                set_ovr;

    logic [4*NDIGIT-1:0] dec_hex;
    logic [NDIGIT-1:0]   dec_en;
    logic [NDIGIT-1:0]   dec_dp;
    logic [NDIGIT-1:0]   dec_err;

    // Per-digit decoders look at the registered sample, so the decoded
    // value always matches the frame the stability counter vouches for.
    for (genvar g = 0; g < NDIGIT; g++) begin : g_dec
        seg_decode_digit u_dec (
            .seg (seg_q[8*g +: 8]),
            .hex (dec_hex[4*g +: 4]),
            .en  (dec_en[g]),
            .dp  (dec_dp[g]),
            .err (dec_err[g])
        );
    end

    // Input sampling and saturating stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '1;
            cnt   <= '0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = (cnt == CNT_MAX);
    // Comparing against the last reported frame (reset to blank) keeps the
    // power-up blank frame silent and lets a stalled frame be picked up later.
    assign fresh  = (seg_q != last);

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        release_v = 1'b0;
        set_ovr   = 1'b0;
        case (state)
            SETTLE: begin
                if (stable && fresh) begin
                    load    = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    release_v = 1'b1;
                    state_n   = SETTLE;
                end else if (stable && fresh) begin
                    set_ovr = 1'b1;
                end
            end
            default: state_n = SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETTLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= '1;
            out_valid <= 1'b0;
            out_hex   <= '0;
            out_en    <= '0;
            out_dp    <= '0;
            out_err   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                last      <= seg_q;
                out_valid <= 1'b1;
                out_hex   <= dec_hex;
                out_en    <= dec_en;
                out_dp    <= dec_dp;
                out_err   <= dec_err;
            end
            if (release_v) begin
                out_valid <= 1'b0;
            end
            if (set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_rx.sv
module tb_seg_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seg_in;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_hex;
    logic [7:0]  out_en;
    logic [7:0]  out_dp;
    logic [7:0]  out_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    seg_rx #(
        .NDIGIT        (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_hex   (out_hex),
        .out_en    (out_en),
        .out_dp    (out_dp),
        .out_err   (out_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    function automatic logic [63:0] frame(input logic [7:0] d3, input logic [7:0] d2,
                                          input logic [7:0] d1, input logic [7:0] d0);
        return {32'hFFFF_FFFF, d3, d2, d1, d0};
    endfunction

    initial begin
        logic seen;
        int   frames;
        logic [31:0] cap_hex;

        // 1: reset, all blank for 50 cycles
        rst       = 1'b1;
        out_ready = 1'b0;
        seg_in    = '1;
        step();
        step();
        chk("rst_valid",   64'(out_valid), 64'd0);
        chk("rst_overrun", 64'(overrun),   64'd0);
        chk("rst_hex",     64'(out_hex),   64'd0);
        chk("rst_en",      64'(out_en),    64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("blank_never_valid", 64'(seen),    64'd0);
        chk("blank_overrun",     64'(overrun), 64'd0);

        // 2: single digit, latency STABLE_CYCLES+2
        seg_in = frame(8'hFF, 8'hFF, 8'hFF, 8'h25);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("lat_not_early", 64'(seen), 64'd0);
        step();
        chk("lat_valid_t6", 64'(out_valid), 64'd1);
        chk("d25_hex", 64'(out_hex), 64'h2);
        chk("d25_en",  64'(out_en),  64'h01);
        chk("d25_dp",  64'(out_dp),  64'h00);
        chk("d25_err", 64'(out_err), 64'h00);
        out_ready = 1'b1;
        step();
        chk("d25_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("d25_no_repeat", 64'(seen), 64'd0);

        // 3: glitching digit, then settles on 0D
        out_ready = 1'b1;
        frames  = 0;
        cap_hex = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0)
                seg_in = (seg_in[7:0] == 8'h25) ? frame(8'hFF, 8'hFF, 8'hFF, 8'h0D)
                                                : frame(8'hFF, 8'hFF, 8'hFF, 8'h25);
            step();
            if (out_valid) begin
                frames++;
                cap_hex = out_hex;
            end
        end
        seg_in = frame(8'hFF, 8'hFF, 8'hFF, 8'h0D);
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) begin
                frames++;
                cap_hex = out_hex;
            end
        end
        chk("glitch_frames", 64'(frames),  64'd1);
        chk("glitch_hex",    64'(cap_hex), 64'h3);
        out_ready = 1'b0;

        // 4: full segments+dp, dp-only blank, unknown pattern
        seg_in = frame(8'hFD, 8'hFE, 8'h00, 8'h0D);
        wait_valid("mix", 20);
        chk("mix_hex", 64'(out_hex), 64'h0000_0083);
        chk("mix_en",  64'(out_en),  64'h03);
        chk("mix_dp",  64'(out_dp),  64'h06);
        chk("mix_err", 64'(out_err), 64'h08);
        out_ready = 1'b1;
        step();
        chk("mix_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // 5: stalled consumer, second frame raises overrun
        seg_in = frame(8'hFF, 8'hFF, 8'hFF, 8'h9F);
        wait_valid("frame_a", 20);
        chk("a_hex",     64'(out_hex), 64'h1);
        chk("a_overrun", 64'(overrun), 64'd0);
        seg_in = frame(8'hFF, 8'hFF, 8'hFF, 8'h99);
        for (int i = 0; i < 10; i++) step();
        chk("ovr_set",     64'(overrun),   64'd1);
        chk("ovr_a_held",  64'(out_hex),   64'h1);
        chk("ovr_a_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        chk("a_accept", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        step();
        chk("b_valid",   64'(out_valid), 64'd1);
        chk("b_hex",     64'(out_hex),   64'h4);
        chk("b_overrun", 64'(overrun),   64'd1);

        // 6: reset while holding, then re-report
        rst = 1'b1;
        step();
        chk("hrst_valid",   64'(out_valid), 64'd0);
        chk("hrst_overrun", 64'(overrun),   64'd0);
        chk("hrst_hex",     64'(out_hex),   64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("rerep_not_early", 64'(seen), 64'd0);
        step();
        chk("rerep_valid",   64'(out_valid), 64'd1);
        chk("rerep_hex",     64'(out_hex),   64'h4);
        chk("rerep_overrun", 64'(overrun),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
